// File: rtl/pipe_chk_pkg.sv
// Shared types and constants for the pipe-in checker.
//   state_e              : checker FSM states
//   SEED_COUNT/SEED_LFSR : generator seeds, two 32-bit lanes
//   LFSR_TAP_*           : feedback taps for x^32 + x^22 + x^2 + 1
//   MASK_ALL             : ready pattern that never throttles
//   lfsr_step/count_step : one-lane advance helpers
package pipe_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [63:0] SEED_COUNT = 64'h0000_0001_0000_0001;
  localparam logic [63:0] SEED_LFSR  = 64'h0D0C_0B0A_0403_0201;

  localparam int unsigned LFSR_TAP_HI  = 31;
  localparam int unsigned LFSR_TAP_MID = 21;
  localparam int unsigned LFSR_TAP_LO  = 1;

  localparam logic [15:0] MASK_ALL = 16'hFFFF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] t);
    return {t[30:0], t[LFSR_TAP_HI] ^ t[LFSR_TAP_MID] ^ t[LFSR_TAP_LO]};
  endfunction

  function automatic logic [31:0] count_step(input logic [31:0] t);
    return t + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_chk_gen.sv
// Reference pattern generator for the pipe-in checker: two independent 32-bit lanes
// that either count up or run a Galois-free Fibonacci LFSR each.
// Ports:
//   clk, reset : clock and synchronous active-high reset (reset = Count seed)
//   load       : reseed from the seed selected by mode and latch mode
//   mode       : 0 = Count, 1 = LFSR; only looked at while load is high
//   advance    : step both lanes one word
//   pattern    : current expected pattern, lanes {g[63:32], g[31:0]}
module pipe_chk_gen
  import pipe_chk_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        mode,
  input  logic        advance,
  output logic [63:0] pattern
);

  logic [63:0] pattern_q, pattern_d;
  logic        mode_q;

  always_comb begin
    pattern_d = pattern_q;
    if (mode_q) begin
      pattern_d = {lfsr_step(pattern_q[63:32]), lfsr_step(pattern_q[31:0])};
    end else begin
      pattern_d = {count_step(pattern_q[63:32]), count_step(pattern_q[31:0])};
    end
  end

  // load outranks advance so a restart always begins on the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= SEED_COUNT;
      mode_q    <= 1'b0;
    end else if (load) begin
      mode_q    <= mode;
      pattern_q <= mode ? SEED_LFSR : SEED_COUNT;
    end else if (advance) begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern = pattern_q;

endmodule

// File: rtl/pipe_in_checker_gen.sv
// Pipe-in checker: compares every accepted host word against a locally regenerated
// Count or LFSR pattern over a length-bounded transfer (IDLE -> RUN -> DONE), with an
// optional rotating ready mask to exercise host backpressure.
// Parameters: DATA_W (16, 32 or 64), LEN_W (length / word counter width).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : pulse; samples mode/xfer_len/throttle_mask, reseeds, clears counters
//   mode              : 0 = Count, 1 = LFSR
//   xfer_len          : words expected, 0 = unbounded
//   throttle_mask     : ready pattern, rotated right each RUN cycle; 0 behaves as all-ones
//   pipe_in_write/data: host word strobe and data
//   pipe_in_ready     : word can be accepted this cycle
//   busy, done        : state is RUN / DONE
//   word_count        : accepted words since start
//   error_count       : mismatching accepted words, saturating
//   overrun_count     : writes while not ready, saturating
// Optional build macro PIPE_CHK_ERR_CAPTURE_EN adds first_err_valid/index/exp/got, which
// latch details of the first mismatch after start.
module pipe_in_checker_gen
  import pipe_chk_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [15:0]       throttle_mask,
  input  logic              pipe_in_write,
  input  logic [DATA_W-1:0] pipe_in_data,
  output logic              pipe_in_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  word_count,
  output logic [31:0]       error_count,
  output logic [15:0]       overrun_count
`ifdef PIPE_CHK_ERR_CAPTURE_EN
  ,
  output logic              first_err_valid,
  output logic [LEN_W-1:0]  first_err_index,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
`endif
);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [15:0]       mask_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_count_q;
  logic [31:0]       error_count_q;
  logic [15:0]       overrun_count_q;

  logic [63:0]       pattern;
  logic [DATA_W-1:0] expected;
  logic              accept, overrun, mismatch, last_word;
  logic [LEN_W-1:0]  word_count_inc;
  logic [15:0]       mask_load;
  logic              unused_pattern;

  assign expected       = pattern[DATA_W-1:0];
  // Upper lane bits are only compared in the 64-bit build.
  assign unused_pattern = ^pattern;

  // Ready depends on registered state only, never on this cycle's write.
  assign pipe_in_ready = (state_q == ST_RUN) & mask_q[0];

  // start takes the cycle: a coincident write is neither accepted nor an overrun.
  assign accept   = pipe_in_write & pipe_in_ready & ~start;
  assign overrun  = pipe_in_write & ~pipe_in_ready & ~start;
  assign mismatch = (pipe_in_data != expected);

  assign word_count_inc = word_count_q + LEN_W'(1);
  assign last_word      = (len_q != '0) && (word_count_inc == len_q);
  // An all-zero mask would never raise ready and hang the host.
  assign mask_load      = (throttle_mask == 16'h0000) ? MASK_ALL : throttle_mask;

  pipe_chk_gen u_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (start),
    .mode    (mode),
    .advance (accept),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mask_q          <= MASK_ALL;
      len_q           <= '0;
      word_count_q    <= '0;
      error_count_q   <= '0;
      overrun_count_q <= '0;
    end else if (start) begin
      state_q         <= ST_RUN;
      busy_q          <= 1'b1;
      done_q          <= 1'b0;
      mask_q          <= mask_load;
      len_q           <= xfer_len;
      word_count_q    <= '0;
      error_count_q   <= '0;
      overrun_count_q <= '0;
    end else begin
      if (state_q == ST_RUN) begin
        // Rotates every RUN cycle regardless of handshakes.
        mask_q <= {mask_q[0], mask_q[15:1]};
      end
      if (accept) begin
        word_count_q <= word_count_inc;
        if (mismatch && (error_count_q != 32'hFFFF_FFFF)) begin
          error_count_q <= error_count_q + 32'd1;
        end
        if (last_word) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
      if (overrun && (overrun_count_q != 16'hFFFF)) begin
        overrun_count_q <= overrun_count_q + 16'd1;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign word_count    = word_count_q;
  assign error_count   = error_count_q;
  assign overrun_count = overrun_count_q;

`ifdef PIPE_CHK_ERR_CAPTURE_EN
  logic              first_err_valid_q;
  logic [LEN_W-1:0]  first_err_index_q;
  logic [DATA_W-1:0] first_err_exp_q;
  logic [DATA_W-1:0] first_err_got_q;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      first_err_valid_q <= 1'b0;
      first_err_index_q <= '0;
      first_err_exp_q   <= '0;
      first_err_got_q   <= '0;
    end else if (accept && mismatch && !first_err_valid_q) begin
      first_err_valid_q <= 1'b1;
      first_err_index_q <= word_count_q;
      first_err_exp_q   <= expected;
      first_err_got_q   <= pipe_in_data;
    end
  end

  assign first_err_valid = first_err_valid_q;
  assign first_err_index = first_err_index_q;
  assign first_err_exp   = first_err_exp_q;
  assign first_err_got   = first_err_got_q;
`endif

endmodule
